// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response handshake plus the RAM port of the
// MEM-stage load/store front end. The slave modport is the unit itself; the
// master modport is the requester side that also owns the RAM.
interface mem_access_unit_if #(
  parameter int ADDR_W = 9
);
  // Request channel
  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [31:0]       req_addr;
  logic [1:0]        req_size;
  logic              req_se;
  logic [31:0]       req_wdata;
  // Response channel
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_fault;
  // RAM port (level-sensitive)
  logic [ADDR_W-1:0] ram_a;
  logic [31:0]       ram_di;
  logic [1:0]        ram_size;
  logic              ram_rw;
  logic              ram_e;
  logic              ram_se;
  logic [31:0]       ram_do;

  modport slave (
    input  req_valid, req_rw, req_addr, req_size, req_se, req_wdata,
    input  resp_ready, ram_do,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output ram_a, ram_di, ram_size, ram_rw, ram_e, ram_se
  );

  modport master (
    output req_valid, req_rw, req_addr, req_size, req_se, req_wdata,
    output resp_ready, ram_do,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  ram_a, ram_di, ram_size, ram_rw, ram_e, ram_se
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: one-at-a-time load/store front end for the byte-addressed
// data RAM. Each accepted request is range/size checked, then presented to the
// RAM from registers for exactly one cycle (ACCESS); the load data is captured
// and returned as a registered response with a fault flag.
// Optional build macro: MEM_ACCESS_ALIGN_CHECK_EN (adds halfword/word
// alignment faults; without it misaligned accesses go to the RAM as-is).
module mem_access_unit #(
  parameter int ADDR_W    = 9,
  parameter int MEM_BYTES = 512
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_unit_if.slave   bus
);

  // End-address arithmetic is two bits wider than the RAM address so that
  // addr + nbytes - 1 cannot wrap back into range.
  localparam int EXT_W = ADDR_W + 2;
  localparam logic [EXT_W-1:0] LAST_BYTE = EXT_W'(MEM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              accept;
  logic              fault_d;
  logic [EXT_W-1:0]  nbytes_m1;
  logic [EXT_W-1:0]  end_addr;

  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              se_q;
  logic [31:0]       wdata_q;
  logic              fault_q;
  logic [31:0]       rdata_q;
  logic              access;

  // Request fault decode: illegal size, out-of-range address, optional misalignment
  always_comb begin
    nbytes_m1 = '0;
    case (bus.req_size)
      2'b01:   nbytes_m1 = EXT_W'(1);
      2'b10:   nbytes_m1 = EXT_W'(3);
      default: nbytes_m1 = '0;
    endcase
    end_addr = {2'b00, bus.req_addr[ADDR_W-1:0]} + nbytes_m1;
    fault_d  = (bus.req_size == 2'b11) || (|bus.req_addr[31:ADDR_W]) ||
               (end_addr > LAST_BYTE);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    if ((bus.req_size == 2'b01) && bus.req_addr[0])
      fault_d = 1'b1;
    if ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00))
      fault_d = 1'b1;
`endif
  end

  // State register; reset drops the FSM (and therefore ram_e) to IDLE immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; faulting requests skip ACCESS and go straight to RESP
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = fault_d ? RESP : ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the request on accept, capture load data at the end of ACCESS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'b00;
      se_q    <= 1'b0;
      wdata_q <= '0;
      fault_q <= 1'b0;
      rdata_q <= '0;
    end else if (accept) begin
      rw_q    <= bus.req_rw;
      addr_q  <= bus.req_addr[ADDR_W-1:0];
      size_q  <= bus.req_size;
      se_q    <= bus.req_se;
      wdata_q <= bus.req_wdata;
      fault_q <= fault_d;
      rdata_q <= '0;
    end else if (state_q == ACCESS) begin
      rdata_q <= rw_q ? 32'h0 : bus.ram_do;
    end
  end

  // RAM port is a decode of the state register and latched fields only, so
  // nothing on req_* can ever reach the RAM combinationally.
  assign access       = (state_q == ACCESS);
  assign bus.ram_e    = access;
  assign bus.ram_a    = access ? addr_q  : '0;
  assign bus.ram_di   = access ? wdata_q : '0;
  assign bus.ram_size = access ? size_q  : 2'b00;
  assign bus.ram_rw   = access & rw_q;
  assign bus.ram_se   = access & se_q;

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_fault = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: drives mem_access_unit against a big-endian RAM model,
// and predicts every response from a separate byte-array reference memory.
module tb_mem_access_unit;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  mem_access_unit_if #(.ADDR_W(9)) bus ();

  mem_access_unit #(.ADDR_W(9), .MEM_BYTES(512)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM environment (big-endian, sign handling) ----------
  logic [7:0] ram_mem [512];
  logic [7:0] ref_mem [512];
  logic [8:0] ra1, ra2, ra3;
  logic [7:0] rb0, rb1, rb2, rb3;

  always_comb begin
    ra1 = bus.ram_a + 9'd1;
    ra2 = bus.ram_a + 9'd2;
    ra3 = bus.ram_a + 9'd3;
    rb0 = ram_mem[bus.ram_a];
    rb1 = ram_mem[ra1];
    rb2 = ram_mem[ra2];
    rb3 = ram_mem[ra3];
    case (bus.ram_size)
      2'b00:   bus.ram_do = bus.ram_se ? {{24{rb0[7]}}, rb0} : {24'h0, rb0};
      2'b01:   bus.ram_do = bus.ram_se ? {{16{rb0[7]}}, rb0, rb1} : {16'h0, rb0, rb1};
      default: bus.ram_do = {rb0, rb1, rb2, rb3};
    endcase
  end

  always @(negedge clk) begin
    if (bus.ram_e && bus.ram_rw) begin
      case (bus.ram_size)
        2'b00: ram_mem[bus.ram_a] <= bus.ram_di[7:0];
        2'b01: begin
          ram_mem[bus.ram_a] <= bus.ram_di[15:8];
          ram_mem[ra1]       <= bus.ram_di[7:0];
        end
        default: begin
          ram_mem[bus.ram_a] <= bus.ram_di[31:24];
          ram_mem[ra1]       <= bus.ram_di[23:16];
          ram_mem[ra2]       <= bus.ram_di[15:8];
          ram_mem[ra3]       <= bus.ram_di[7:0];
        end
      endcase
    end
  end

  // ---------------- reference model ----------------
  function automatic int nbytes_of(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic model_fault(input logic [31:0] addr, input logic [1:0] size);
    longint last;
    logic f;
    last = longint'(addr) + nbytes_of(size) - 1;
    f = (size == 2'b11) || (addr > 32'd511) || (last > 511);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    if (size == 2'b01 && (addr % 2) != 0) f = 1'b1;
    if (size == 2'b10 && (addr % 4) != 0) f = 1'b1;
`endif
    return f;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                             input logic se);
    logic [31:0] v;
    int nb;
    nb = nbytes_of(size);
    v = 0;
    for (int k = 0; k < nb; k++) v = (v << 8) | 32'(ref_mem[addr + k]);
    if (se && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
    return v;
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [1:0] size,
                             input logic [31:0] wdata);
    logic [31:0] t;
    int nb;
    nb = nbytes_of(size);
    for (int k = 0; k < nb; k++) begin
      t = wdata >> (8 * (nb - 1 - k));
      ref_mem[addr + k] = t[7:0];
    end
  endtask

  // ---------------- transaction driver (observes, does not judge) --------
  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_txn(input logic rw, input logic [31:0] addr, input logic [1:0] size,
                         input logic se, input logic [31:0] wdata, input int hold,
                         output logic fault, output logic [31:0] rdata,
                         output int lat, output int ecnt, output int rbad, output logic tmo);
    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_addr  = addr;
    bus.req_size  = size;
    bus.req_se    = se;
    bus.req_wdata = wdata;
    @(posedge clk);
    lat = 0; ecnt = 0; rbad = 0; tmo = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) bus.req_valid = 1'b0;
      lat = i + 1;
      if (bus.ram_e) ecnt++;
      else if (bus.ram_rw || bus.ram_se || bus.ram_a != 0 || bus.ram_di != 0 ||
               bus.ram_size != 0) rbad++;
      if (bus.resp_valid) begin
        tmo = 1'b0;
        break;
      end
    end
    fault = bus.resp_fault;
    rdata = bus.resp_rdata;
    repeat (hold) @(negedge clk);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    $display("txn rw=%0d addr=%08h size=%0d se=%0d wdata=%08h -> fault=%0d rdata=%08h lat=%0d",
             rw, addr, size, se, wdata, fault, rdata, lat);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_addr = '0; bus.req_size = '0;
    bus.req_se = 1'b0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_req_ready got %b want 1", bus.req_ready); end
    n_vec++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid); end
    n_vec++; if (bus.resp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_resp_rdata got %08h want 0", bus.resp_rdata); end
    n_vec++; if (bus.resp_fault !== 1'b0) begin n_err++; $display("FAIL reset_resp_fault got %b want 0", bus.resp_fault); end
    n_vec++;
    if ({bus.ram_e, bus.ram_rw, bus.ram_se, bus.ram_size, bus.ram_a, bus.ram_di} !== '0) begin
      n_err++; $display("FAIL reset_ram_port got e=%b rw=%b a=%h di=%h want all 0",
                        bus.ram_e, bus.ram_rw, bus.ram_a, bus.ram_di);
    end
  endtask

  task automatic test_word();
    logic f; logic [31:0] d; int lat, ec, rb; logic to;
    run_txn(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 0, f, d, lat, ec, rb, to);
    model_store(32'h10, 2'b10, 32'hDEADBEEF);
    n_vec++; if (to || f !== 1'b0 || d !== 32'h0) begin n_err++; $display("FAIL store_word_resp got fault=%b rdata=%08h tmo=%b want 0/0", f, d, to); end
    n_vec++; if (ec != 1) begin n_err++; $display("FAIL store_word_ram_e got %0d cycles want 1", ec); end
    run_txn(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1, f, d, lat, ec, rb, to);
    n_vec++; if (d !== 32'hDEADBEEF) begin n_err++; $display("FAIL load_word_rdata got %08h want deadbeef", d); end
    n_vec++; if (f !== 1'b0) begin n_err++; $display("FAIL load_word_fault got %b want 0", f); end
    n_vec++; if (lat != 2 || to) begin n_err++; $display("FAIL load_word_latency got %0d want 2", lat); end
    n_vec++; if (ec != 1 || rb != 0) begin n_err++; $display("FAIL load_word_ram_e got %0d cycles (%0d stray) want 1", ec, rb); end
  endtask

  task automatic test_byte_sign();
    logic f; logic [31:0] d; int lat, ec, rb; logic to;
    run_txn(1'b1, 32'h20, 2'b00, 1'b0, 32'h12345680, 0, f, d, lat, ec, rb, to);
    model_store(32'h20, 2'b00, 32'h12345680);
    run_txn(1'b0, 32'h20, 2'b00, 1'b1, 32'h0, 0, f, d, lat, ec, rb, to);
    n_vec++; if (d !== 32'hFFFFFF80 || f !== 1'b0) begin n_err++; $display("FAIL load_byte_se got %08h want ffffff80", d); end
    run_txn(1'b0, 32'h20, 2'b00, 1'b0, 32'h0, 0, f, d, lat, ec, rb, to);
    n_vec++; if (d !== 32'h00000080 || f !== 1'b0) begin n_err++; $display("FAIL load_byte_zx got %08h want 00000080", d); end
  endtask

  task automatic test_range_fault();
    logic f; logic [31:0] d; int lat, ec, rb; logic to;
    logic [31:0] addrs [2];
    addrs[0] = 32'd510;
    addrs[1] = 32'h200;
    for (int i = 0; i < 2; i++) begin
      run_txn(1'b0, addrs[i], 2'b10, 1'b0, 32'h0, 0, f, d, lat, ec, rb, to);
      n_vec++; if (f !== 1'b1) begin n_err++; $display("FAIL range_fault_%0d got %b want 1", i, f); end
      n_vec++; if (lat != 1 || to) begin n_err++; $display("FAIL range_latency_%0d got %0d want 1", i, lat); end
      n_vec++; if (ec != 0 || rb != 0) begin n_err++; $display("FAIL range_ram_e_%0d got %0d want 0", i, ec); end
      n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL range_rdata_%0d got %08h want 0", i, d); end
    end
    // store with size 11 must fault and leave memory untouched
    run_txn(1'b1, 32'h40, 2'b11, 1'b0, 32'hA5A5A5A5, 0, f, d, lat, ec, rb, to);
    n_vec++; if (f !== 1'b1 || ec != 0) begin n_err++; $display("FAIL size11_fault got fault=%b ram_e=%0d want 1/0", f, ec); end
  endtask

  task automatic test_misaligned();
    logic f; logic [31:0] d; int lat, ec, rb; logic to;
    run_txn(1'b0, 32'h11, 2'b01, 1'b0, 32'h0, 0, f, d, lat, ec, rb, to);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    n_vec++; if (f !== 1'b1 || ec != 0 || d !== 32'h0) begin n_err++; $display("FAIL misaligned_half got fault=%b rdata=%08h want 1/0", f, d); end
`else
    n_vec++; if (f !== 1'b0 || d !== 32'h0000ADBE) begin n_err++; $display("FAIL misaligned_half got fault=%b rdata=%08h want 0/0000adbe", f, d); end
`endif
  endtask

  task automatic test_random();
    logic f; logic [31:0] d; int lat, ec, rb; logic to;
    logic rw, se, ef; logic [31:0] addr, wd, ed; logic [1:0] size; int r;
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      addr = $urandom;
      else if (r == 1) addr = $urandom_range(500, 520);
      else             addr = $urandom_range(0, 511);
      size = 2'($urandom_range(0, 3));
      rw   = 1'($urandom_range(0, 1));
      se   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      ef   = model_fault(addr, size);
      ed   = (ef || rw) ? 32'h0 : model_load(addr, size, se);
      run_txn(rw, addr, size, se, wd, $urandom_range(0, 2), f, d, lat, ec, rb, to);
      if (!ef && rw) model_store(addr, size, wd);
      n_vec++;
      if (to || f !== ef || d !== ed || lat != (ef ? 1 : 2) || ec != (ef ? 0 : 1) || rb != 0) begin
        n_err++;
        $display("FAIL random_%0d addr=%08h size=%0d rw=%0d got fault=%b rdata=%08h lat=%0d e=%0d want fault=%b rdata=%08h",
                 n, addr, size, rw, f, d, lat, ec, ef, ed);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] snap, ed; logic seen;
    ed = model_load(32'h10, 2'b10, 1'b0);
    bus.req_valid = 1'b1; bus.req_rw = 1'b0; bus.req_addr = 32'h10;
    bus.req_size = 2'b10; bus.req_se = 1'b0;
    @(posedge clk);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.resp_valid) begin seen = 1'b1; break; end
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL bp_resp_valid got 0 want 1 (timeout)"); end
    snap = bus.resp_rdata;
    n_vec++; if (snap !== ed) begin n_err++; $display("FAIL bp_rdata got %08h want %08h", snap, ed); end
    // a competing store is presented while the response is held; it must be ignored
    bus.req_valid = 1'b1; bus.req_rw = 1'b1; bus.req_addr = 32'h10;
    bus.req_size = 2'b10; bus.req_wdata = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== snap || bus.req_ready !== 1'b0 || bus.ram_e !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold_%0d got valid=%b rdata=%08h ready=%b ram_e=%b want 1/%08h/0/0",
                 i, bus.resp_valid, bus.resp_rdata, bus.req_ready, bus.ram_e, snap);
      end
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    n_vec++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL bp_release got ready=%b valid=%b want 1/0", bus.req_ready, bus.resp_valid); end
    $display("txn backpressure load addr=00000010 rdata=%08h held 5 cycles", snap);
  endtask

  task automatic test_reset_mid_access();
    bus.req_valid = 1'b1; bus.req_rw = 1'b1; bus.req_addr = 32'h100;
    bus.req_size = 2'b10; bus.req_se = 1'b0; bus.req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #2;
    n_vec++; if (bus.ram_e !== 1'b1) begin n_err++; $display("FAIL rst_access_ram_e got %b want 1", bus.ram_e); end
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    n_vec++; if (bus.ram_e !== 1'b0 || bus.ram_rw !== 1'b0) begin n_err++; $display("FAIL rst_async_ram_e got e=%b rw=%b want 0/0", bus.ram_e, bus.ram_rw); end
    n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rst_async_idle got ready=%b want 1", bus.req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_vec++;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.ram_e !== 1'b0) begin
        n_err++; $display("FAIL rst_after got valid=%b ready=%b ram_e=%b want 0/1/0", bus.resp_valid, bus.req_ready, bus.ram_e);
      end
    end
    $display("txn reset during store access addr=00000100");
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 512; i++) begin
      ram_mem[i] = 8'(i * 37 + 5);
      ref_mem[i] = 8'(i * 37 + 5);
    end
    test_reset();
    test_word();
    test_byte_sign();
    test_range_fault();
    test_misaligned();
    test_backpressure();
    test_random();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sequential load/store front end sitting directly upstream of the 512-byte data RAM in the MEM stage. It accepts one load/store request at a time over a valid/ready handshake, checks size and range, and drives the RAM's level-sensitive port (A, DI, Size, RW, E, SE) from registers for exactly one cycle. It then captures the load data and returns a registered response with a fault flag. Isolating the RAM's async writes to a single registered access cycle is the reason this block exists.

## Interface
- `ADDR_W`, 9: RAM byte-address width.
- `MEM_BYTES`, 512: RAM size in bytes; the last valid byte is `MEM_BYTES-1`.
- `clk`  in  1  the only clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept; high only in IDLE.
- `req_rw`  in  1  0 = load, 1 = store.
- `req_addr`  in  32  byte address (ALU result).
- `req_size`  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- `req_se`  in  1  sign-extend loads.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes the response.
- `resp_rdata`  out  32  load data; 0 for stores and faults.
- `resp_fault`  out  1  request was rejected without a RAM access.
- `ram_a`  out  ADDR_W  to RAM A.
- `ram_di`  out  32  to RAM DI.
- `ram_size`  out  2  to RAM Size.
- `ram_rw`  out  1  to RAM RW.
- `ram_e`  out  1  to RAM E.
- `ram_se`  out  1  to RAM SE.
- `ram_do`  in  32  from RAM DO.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE
  - `req_ready` = 1.
  - On `req_valid && req_ready`, latch rw, addr[ADDR_W-1:0], size, se, wdata, and compute the fault.
  - fault = 0: go to ACCESS. fault = 1: go to RESP with `resp_fault` = 1, with no RAM activity.
- Fault conditions:
  - `req_size` = 11.
  - `req_addr[31:ADDR_W]` ≠ 0.
  - addr + nbytes − 1 > MEM_BYTES − 1, where nbytes is 1, 2 or 4. Compute this at ADDR_W+2 bits so it cannot wrap.
  - The alignment checks listed under Configuration.
- ACCESS (exactly one cycle)
  - `ram_e` = 1.
  - `ram_a`, `ram_size`, `ram_rw`, `ram_se` and `ram_di` come from the latched registers.
  - Load: capture `ram_do` into `resp_rdata` at the end of the cycle.
  - Store: `resp_rdata` = 0.
  - Next state is RESP.
- RESP
  - `resp_valid` = 1. `resp_rdata` and `resp_fault` are held stable.
  - Leave to IDLE on `resp_ready`.
  - There is no bypass: a new request is accepted only in the cycle after the response is taken.
- Outside ACCESS, all `ram_*` outputs are 0 (`ram_e` = 0, `ram_rw` = 0 = read). The RAM is therefore never enabled and never sees a spurious store.
- All `ram_*` outputs are registers or a pure decode of the state register plus latched registers. No combinational path runs from any `req_*` input to any `ram_*` output.
- Data format:
  - Big-endian and sign handling are performed by the RAM.
  - This block passes `ram_do` through unchanged and does no byte-lane shifting.

## Timing
- Request accepted at edge N.
- ACCESS occupies cycle N→N+1.
- `resp_valid` rises after edge N+1.
- A faulting request gets `resp_valid` after edge N, one cycle earlier, and never enters ACCESS.
- Peak throughput is one request per 3 cycles. A fault with `resp_ready` held high takes 2 cycles.
- `resp_valid` held while `resp_ready` = 0 keeps the FSM in RESP indefinitely with all outputs frozen.
- `req_*` inputs are ignored outside IDLE.
- Reset values: `req_ready` = 1, `resp_valid` = 0, `resp_rdata` = 0, `resp_fault` = 0, all `ram_*` = 0.
- Reset asserted mid-ACCESS drops `ram_e` immediately, without waiting for a clock edge.
  - A store in progress may or may not have written.
  - No response is produced for it.

## Configuration
- `MEM_ACCESS_ALIGN_CHECK_EN` defined:
  - A halfword with addr[0] ≠ 0 faults.
  - A word with addr[1:0] ≠ 0 faults.
- `MEM_ACCESS_ALIGN_CHECK_EN` undefined:
  - Misaligned accesses are issued to the RAM as-is. The RAM is byte-addressed, so they complete normally.
  - Only the size and range faults apply.

## Test plan
- Store word: wdata 0xDEADBEEF at addr 0x10, then load word from 0x10 → `ram_e` high for exactly 1 cycle per request; load response `resp_rdata` = 0xDEADBEEF, `resp_fault` = 0, `resp_valid` 2 cycles after accept.
- Store byte: 0x80 at addr 0x20.
  - Load byte with se = 1 → 0xFFFFFF80.
  - Load byte with se = 0 → 0x00000080.
- Load word at addr 510, and separately at addr 0x200 → `resp_fault` = 1 after 1 cycle, `ram_e` never asserted, `resp_rdata` = 0.
- Load halfword at addr 0x11, run once with the macro and once without:
  - Macro defined: `resp_fault` = 1.
  - Macro undefined: `resp_fault` = 0 and the data is the RAM's {Mem[0x11], Mem[0x12]}.
- Backpressure: hold `resp_ready` = 0 for 5 cycles → `resp_valid` and `resp_rdata` stable and `req_ready` = 0 throughout; `req_ready` = 1 in the cycle after `resp_ready` rises.
- Assert `rst_n` low during ACCESS of a store → `ram_e` = 0 with no clock edge, state IDLE, `resp_valid` = 0, `req_ready` = 1 after reset releases.
